// File: rtl/conv_window_buf.sv
// Sliding-window line buffer: turns a raster pixel stream into KSIZE x KSIZE
// windows (flattened, fixed element order) with position tags and frame_done.
module conv_window_buf #(
  parameter int WIDTH    = 28,
  parameter int HEIGHT   = 28,
  parameter int DATA_BIT = 8,
  parameter int KSIZE    = 5,
  parameter int STRIDE   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [DATA_BIT-1:0]             in_data,
  output logic                            out_valid,
  output logic [KSIZE*KSIZE*DATA_BIT-1:0] out_window,
  output logic [$clog2(HEIGHT)-1:0]       out_row,
  output logic [$clog2(WIDTH)-1:0]        out_col,
  output logic                            frame_done
);

  // Stream protocol: a pixel transfers on every rising edge with in_valid=1
  // (no ready, no backpressure); out_valid is a one-cycle pulse per window and
  // out_window/out_row/out_col hold their last values while it is low.

  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);
  localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  // Top-left corner of the last window in a frame (stride-aligned).
  localparam int LAST_R = ((HEIGHT - KSIZE) / STRIDE) * STRIDE;
  localparam int LAST_C = ((WIDTH - KSIZE) / STRIDE) * STRIDE;

  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] K_M1_R   = ROW_W'(KSIZE - 1);
  localparam logic [COL_W-1:0] K_M1_C   = COL_W'(KSIZE - 1);
  localparam logic [ROW_W-1:0] LAST_R_T = ROW_W'(LAST_R);
  localparam logic [COL_W-1:0] LAST_C_T = COL_W'(LAST_C);
  localparam logic [PH_W-1:0]  PH_MAX   = PH_W'(STRIDE - 1);

  logic [ROW_W-1:0] in_row;
  logic [COL_W-1:0] in_col;
  logic [PH_W-1:0]  row_ph;
  logic [PH_W-1:0]  col_ph;

  logic [DATA_BIT-1:0] line_mem [KSIZE-1][WIDTH];

  logic [KSIZE-2:0][DATA_BIT-1:0]             tap;
  logic [KSIZE-1:0][DATA_BIT-1:0]             col_vec;
  logic [KSIZE-1:0][KSIZE-1:0][DATA_BIT-1:0]  win;
  logic [KSIZE-1:0][KSIZE-1:0][DATA_BIT-1:0]  win_nx;

  logic             row_ready;
  logic             col_ready;
  logic             last_col;
  logic             last_row;
  logic             emit;
  logic             emit_last;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;

  always_comb begin
    row_ready = (in_row >= K_M1_R);
    col_ready = (in_col >= K_M1_C);
    last_col  = (in_col == COL_MAX);
    last_row  = (in_row == ROW_MAX);
    win_row   = in_row - K_M1_R;
    win_col   = in_col - K_M1_C;
    emit      = in_valid && row_ready && col_ready &&
                (row_ph == '0) && (col_ph == '0);
    emit_last = emit && (win_row == LAST_R_T) && (win_col == LAST_C_T);
  end

  // Line buffers form a cascade: tap[k] is the pixel k+1 rows above the
  // incoming one at the same column, so window rows never need rotating.
  always_comb begin
    tap = '0;
    for (int k = 0; k < KSIZE - 1; k++) begin
      tap[k] = line_mem[k][in_col];
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      line_mem[0][in_col] <= in_data;
      for (int k = 1; k < KSIZE - 1; k++) begin
        line_mem[k][in_col] <= tap[k-1];
      end
    end
  end

  // Incoming column, top row first; the window shifts left by one column.
  always_comb begin
    col_vec = '0;
    col_vec[KSIZE-1] = in_data;
    for (int i = 0; i < KSIZE - 1; i++) begin
      col_vec[i] = tap[KSIZE-2-i];
    end
    win_nx = '0;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE - 1; j++) begin
        win_nx[i][j] = win[i][j+1];
      end
      win_nx[i][KSIZE-1] = col_vec[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_row     <= '0;
      in_col     <= '0;
      row_ph     <= '0;
      col_ph     <= '0;
      win        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit_last;
      if (emit) begin
        out_window <= win_nx;
        out_row    <= win_row;
        out_col    <= win_col;
      end
      if (in_valid) begin
        win <= win_nx;
        if (last_col) begin
          in_col <= '0;
          col_ph <= '0;
          in_row <= last_row ? '0 : in_row + 1'b1;
          // Row phase only starts counting once full windows are possible.
          if (last_row) begin
            row_ph <= '0;
          end else if (row_ready) begin
            row_ph <= (row_ph == PH_MAX) ? '0 : row_ph + 1'b1;
          end
        end else begin
          in_col <= in_col + 1'b1;
          if (col_ready) begin
            col_ph <= (col_ph == PH_MAX) ? '0 : col_ph + 1'b1;
          end
        end
      end
    end
  end

endmodule
